// File: rtl/mmc_cmd_ctrl_if.sv
// Host and pad-side signal bundle of the MMC command-line engine.
// The master side is the host/register block plus the pad model; the slave
// side is the engine itself.
interface mmc_cmd_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        rsp_exp;
  logic        rsp_valid;
  logic [5:0]  rsp_idx;
  logic [31:0] rsp_arg;
  logic        rsp_crc_err;
  logic        rsp_timeout;
  logic        cmd_o;
  logic        cmd_oe;
  logic        cmd_i;
  logic        busy;

  modport master (
    output cmd_valid, cmd_idx, cmd_arg, rsp_exp, cmd_i,
    input  cmd_ready, rsp_valid, rsp_idx, rsp_arg, rsp_crc_err, rsp_timeout,
           cmd_o, cmd_oe, busy
  );

  modport slave (
    input  cmd_valid, cmd_idx, cmd_arg, rsp_exp, cmd_i,
    output cmd_ready, rsp_valid, rsp_idx, rsp_arg, rsp_crc_err, rsp_timeout,
           cmd_o, cmd_oe, busy
  );
endinterface

// File: rtl/mmc_cmd_ctrl.sv
// MMC/SD command-line engine: serializes a 48-bit command frame with CRC7,
// optionally captures and checks a 48-bit short response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a new command
// S_TX     | driving the 48 command bits, MSB first, one per clk_en
// S_TURN   | line released, waiting TURN_CYC strobes
// S_WAIT   | searching for the response start bit, up to RSP_TIMEOUT
// S_RX     | shifting in the remaining 47 response bits
// S_GAP    | NCC idle, GAP_CYC strobes before ready
module mmc_cmd_ctrl #(
  parameter int RSP_TIMEOUT = 64,
  parameter int TURN_CYC    = 2,
  parameter int GAP_CYC     = 8
) (
  input logic          clk,
  input logic          rst_n,
  input logic          clk_en,
  mmc_cmd_ctrl_if.slave bus
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TX   = 3'd1,
    S_TURN = 3'd2,
    S_WAIT = 3'd3,
    S_RX   = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  // x^7 + x^3 + 1, one bit, MSB-first
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [47:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]  crc_q, crc_d;
  logic        rsp_exp_q, rsp_exp_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [5:0]  rsp_idx_q, rsp_idx_d;
  logic [31:0] rsp_arg_q, rsp_arg_d;
  logic        crc_err_q, crc_err_d;
  logic        timeout_q, timeout_d;

  logic        accept;
  logic        cnt_done;
  logic [6:0]  tx_crc;
  // Response frame bits 46..0 as they stand once the current bit is shifted in
  logic [46:0] rx_tail;

  assign accept   = bus.cmd_valid && (state_q == S_IDLE);
  assign cnt_done = (cnt_q <= CW'(1));
  assign tx_crc   = crc7_40({2'b01, bus.cmd_idx, bus.cmd_arg});
  assign rx_tail  = {sh_q[45:0], bus.cmd_i};

  // Next-state, datapath and result update
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    rsp_exp_d   = rsp_exp_q;
    rsp_valid_d = 1'b0;
    rsp_idx_d   = rsp_idx_q;
    rsp_arg_d   = rsp_arg_q;
    crc_err_d   = crc_err_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_TX;
          sh_d      = {2'b01, bus.cmd_idx, bus.cmd_arg, tx_crc, 1'b1};
          cnt_d     = CW'(48);
          rsp_exp_d = bus.rsp_exp;
          crc_err_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_TX: begin
        if (clk_en) begin
          sh_d = {sh_q[46:0], 1'b1};
          if (cnt_done) begin
            state_d = rsp_exp_q ? S_TURN : S_GAP;
            cnt_d   = rsp_exp_q ? CW'(TURN_CYC) : CW'(GAP_CYC);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_TURN: begin
        if (clk_en) begin
          if (cnt_done) begin
            state_d = S_WAIT;
            cnt_d   = CW'(RSP_TIMEOUT);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_WAIT: begin
        if (clk_en) begin
          if (!bus.cmd_i) begin
            state_d = S_RX;
            cnt_d   = CW'(47);
            sh_d    = {sh_q[46:0], 1'b0};
            crc_d   = crc7_step(7'd0, 1'b0);
          end else if (cnt_done) begin
            state_d     = S_GAP;
            cnt_d       = CW'(GAP_CYC);
            timeout_d   = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_RX: begin
        if (clk_en) begin
          sh_d = {sh_q[46:0], bus.cmd_i};
          // cnt > 8 means the incoming bit index is still below 40
          if (cnt_q > CW'(8)) crc_d = crc7_step(crc_q, bus.cmd_i);
          if (cnt_done) begin
            state_d     = S_GAP;
            cnt_d       = CW'(GAP_CYC);
            rsp_idx_d   = rx_tail[45:40];
            rsp_arg_d   = rx_tail[39:8];
            crc_err_d   = (rx_tail[7:1] != crc_q) | rx_tail[46] | ~rx_tail[0];
            rsp_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_GAP: begin
        if (clk_en) begin
          if (cnt_done) state_d = S_IDLE;
          else          cnt_d   = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sh_q        <= '1;
      cnt_q       <= '0;
      crc_q       <= '0;
      rsp_exp_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_arg_q   <= '0;
      crc_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      rsp_exp_q   <= rsp_exp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_arg_q   <= rsp_arg_d;
      crc_err_q   <= crc_err_d;
      timeout_q   <= timeout_d;
    end
  end

  // The line is driven only in TX and idles high otherwise
  assign bus.cmd_oe      = (state_q == S_TX);
  assign bus.cmd_o       = (state_q != S_TX) | sh_q[47];
  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_idx     = rsp_idx_q;
  assign bus.rsp_arg     = rsp_arg_q;
  assign bus.rsp_crc_err = crc_err_q;
  assign bus.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_mmc_cmd_ctrl.sv
// Directed bench for mmc_cmd_ctrl: command framing, response capture,
// CRC/end-bit errors, timeout, clk_en stalls and mid-frame reset.
module tb_mmc_cmd_ctrl;
  localparam int TURN_CYC    = 2;
  localparam int RSP_TIMEOUT = 64;
  localparam int GAP_CYC     = 8;

  localparam logic [47:0] CMD0_FRAME = 48'h400000000095;
  localparam logic [47:0] CMD8_FRAME = 48'h48000001AA87;
  localparam logic [47:0] R7_FRAME   = 48'h08000001AA13;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b0;

  mmc_cmd_ctrl_if bus ();

  mmc_cmd_ctrl #(
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .TURN_CYC   (TURN_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_en(clk_en),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   rv_cnt   = 0;
  int   rv0;
  logic s_oe, s_o, rdy_after;
  logic rnd_gaps = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (bus.rsp_valid) rv_cnt++;
  endtask

  // One card clock: strobe cycle followed by idle cycles
  task automatic tick();
    int idle;
    idle   = rnd_gaps ? int'($urandom_range(0, 6)) : 3;
    clk_en = 1'b1;
    s_oe   = bus.cmd_oe;
    s_o    = bus.cmd_o;
    cyc();
    clk_en    = 1'b0;
    rdy_after = bus.cmd_ready;
    repeat (idle) cyc();
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic exp, input logic hold);
    bus.cmd_valid = 1'b1;
    bus.cmd_idx   = idx;
    bus.cmd_arg   = arg;
    bus.rsp_exp   = exp;
    cyc();
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic run_tx(input string tag, input logic [47:0] exp_frame);
    logic [47:0] f;
    int n;
    f = '0;
    n = 0;
    for (int t = 0; t < 200 && n < 48; t++) begin
      tick();
      if (s_oe) begin
        f = {f[46:0], s_o};
        n++;
      end
    end
    check_val({tag, " frame"}, 64'(f), 64'(exp_frame));
    tick();
    check_val({tag, " oe after end bit"}, 64'(s_oe), 64'd0);
  endtask

  task automatic wait_ready(input string tag, input int exp_ticks);
    int t;
    t = 0;
    rdy_after = 1'b0;
    while (!rdy_after && t < 300) begin
      tick();
      t++;
    end
    check_val({tag, " strobes to ready"}, 64'(t), 64'(exp_ticks));
  endtask

  // Card side: run_tx already consumed the first TURN strobe
  task automatic respond(input logic [47:0] f, input int delay);
    bus.cmd_i = 1'b1;
    repeat (TURN_CYC - 1 + delay) tick();
    for (int i = 47; i >= 0; i--) begin
      bus.cmd_i = f[i];
      tick();
    end
    bus.cmd_i = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    bus.cmd_valid = 1'b0;
    bus.cmd_idx   = '0;
    bus.cmd_arg   = '0;
    bus.rsp_exp   = 1'b0;
    bus.cmd_i     = 1'b1;
    repeat (3) @(negedge clk);

    check_val("rst cmd_ready",   64'(bus.cmd_ready),   64'd1);
    check_val("rst cmd_o",       64'(bus.cmd_o),       64'd1);
    check_val("rst cmd_oe",      64'(bus.cmd_oe),      64'd0);
    check_val("rst rsp_valid",   64'(bus.rsp_valid),   64'd0);
    check_val("rst rsp_idx",     64'(bus.rsp_idx),     64'd0);
    check_val("rst rsp_arg",     64'(bus.rsp_arg),     64'd0);
    check_val("rst rsp_crc_err", 64'(bus.rsp_crc_err), 64'd0);
    check_val("rst rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check_val("rst busy",        64'(bus.busy),        64'd0);
    rst_n = 1'b1;
    cyc();

    // CMD0, no response
    rv0 = rv_cnt;
    send(6'd0, 32'h0, 1'b0, 1'b0);
    check_val("cmd0 busy after accept",  64'(bus.busy),      64'd1);
    check_val("cmd0 ready after accept", 64'(bus.cmd_ready), 64'd0);
    run_tx("cmd0", CMD0_FRAME);
    wait_ready("cmd0", GAP_CYC - 1);
    check_val("cmd0 rsp_valid count", 64'(rv_cnt - rv0), 64'd0);

    // CMD8 with a clean R7 response
    rv0 = rv_cnt;
    send(6'd8, 32'h000001AA, 1'b1, 1'b0);
    run_tx("cmd8", CMD8_FRAME);
    respond(R7_FRAME, 5);
    check_val("cmd8 rsp_valid count", 64'(rv_cnt - rv0),     64'd1);
    check_val("cmd8 rsp_idx",         64'(bus.rsp_idx),      64'd8);
    check_val("cmd8 rsp_arg",         64'(bus.rsp_arg),      64'h1AA);
    check_val("cmd8 crc_err",         64'(bus.rsp_crc_err),  64'd0);
    check_val("cmd8 timeout",         64'(bus.rsp_timeout),  64'd0);
    wait_ready("cmd8", GAP_CYC);

    // Response with a flipped CRC bit
    rv0 = rv_cnt;
    send(6'd8, 32'h000001AA, 1'b1, 1'b0);
    run_tx("crcbad", CMD8_FRAME);
    respond(R7_FRAME ^ 48'h2, 5);
    check_val("crcbad rsp_valid count", 64'(rv_cnt - rv0),    64'd1);
    check_val("crcbad crc_err",         64'(bus.rsp_crc_err), 64'd1);
    check_val("crcbad rsp_idx",         64'(bus.rsp_idx),     64'd8);
    check_val("crcbad rsp_arg",         64'(bus.rsp_arg),     64'h1AA);
    wait_ready("crcbad", GAP_CYC);

    // Response with end bit 0
    rv0 = rv_cnt;
    send(6'd8, 32'h000001AA, 1'b1, 1'b0);
    check_val("endbad crc_err cleared at accept", 64'(bus.rsp_crc_err), 64'd0);
    run_tx("endbad", CMD8_FRAME);
    respond(R7_FRAME ^ 48'h1, 5);
    check_val("endbad rsp_valid count", 64'(rv_cnt - rv0),    64'd1);
    check_val("endbad crc_err",         64'(bus.rsp_crc_err), 64'd1);
    check_val("endbad rsp_arg",         64'(bus.rsp_arg),     64'h1AA);
    wait_ready("endbad", GAP_CYC);

    // No response: timeout after TURN_CYC + RSP_TIMEOUT strobes
    rv0 = rv_cnt;
    send(6'd8, 32'h000001AA, 1'b1, 1'b0);
    check_val("tmo crc_err cleared at accept", 64'(bus.rsp_crc_err), 64'd0);
    bus.cmd_i = 1'b1;
    run_tx("tmo", CMD8_FRAME);
    t = 1;
    while (rv_cnt == rv0 && t < 300) begin
      tick();
      t++;
    end
    check_val("tmo strobes to rsp_valid", 64'(t), 64'(TURN_CYC + RSP_TIMEOUT));
    check_val("tmo rsp_timeout",  64'(bus.rsp_timeout), 64'd1);
    check_val("tmo crc_err",      64'(bus.rsp_crc_err), 64'd0);
    check_val("tmo rsp_idx held", 64'(bus.rsp_idx),     64'd8);
    wait_ready("tmo", GAP_CYC);

    // cmd_valid held through TX with random clk_en gaps
    rnd_gaps = 1'b1;
    rv0 = rv_cnt;
    send(6'd8, 32'h000001AA, 1'b0, 1'b1);
    bus.cmd_idx = 6'd0;
    bus.cmd_arg = 32'h0;
    run_tx("stall1", CMD8_FRAME);
    wait_ready("stall1", GAP_CYC - 1);
    if (bus.cmd_ready) cyc();
    bus.cmd_valid = 1'b0;
    check_val("stall second accept busy", 64'(bus.busy), 64'd1);
    run_tx("stall2", CMD0_FRAME);
    wait_ready("stall2", GAP_CYC - 1);
    check_val("stall rsp_valid count", 64'(rv_cnt - rv0), 64'd0);
    rnd_gaps = 1'b0;

    // Reset during the 20th TX bit
    send(6'd0, 32'h0, 1'b0, 1'b0);
    repeat (19) tick();
    check_val("pre-reset oe", 64'(s_oe), 64'd1);
    clk_en = 1'b1;
    rst_n  = 1'b0;
    cyc();
    check_val("mid-reset cmd_oe",    64'(bus.cmd_oe),    64'd0);
    check_val("mid-reset cmd_o",     64'(bus.cmd_o),     64'd1);
    check_val("mid-reset cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_val("mid-reset busy",      64'(bus.busy),      64'd0);
    check_val("mid-reset rsp_idx",   64'(bus.rsp_idx),   64'd0);
    clk_en = 1'b0;
    rst_n  = 1'b1;
    cyc();
    send(6'd0, 32'h0, 1'b0, 1'b0);
    run_tx("post-reset", CMD0_FRAME);
    wait_ready("post-reset", GAP_CYC - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
